// File: rtl/bob_except_scan.sv
// rtl/bob_except_scan.sv - retire-side scan of one exception-RAM bundle for the first flagged slot
`ifndef EXCEPT_WIDTH
`define EXCEPT_WIDTH 8
`endif

module bob_except_scan #(
  parameter int DATA_WIDTH = `EXCEPT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            req_addr,
  input  logic [9:0]            req_mask,
  input  logic                  flush,
  output logic                  read_step,
  output logic [5:0]            read_addr,
  input  logic [DATA_WIDTH-1:0] read_data0,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  input  logic [DATA_WIDTH-1:0] read_data3,
  input  logic [DATA_WIDTH-1:0] read_data4,
  input  logic [DATA_WIDTH-1:0] read_data5,
  input  logic [DATA_WIDTH-1:0] read_data6,
  input  logic [DATA_WIDTH-1:0] read_data7,
  input  logic [DATA_WIDTH-1:0] read_data8,
  input  logic [DATA_WIDTH-1:0] read_data9,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_found,
  output logic [3:0]            res_slot,
  output logic [DATA_WIDTH-2:0] res_code,
  output logic [3:0]            res_retire_cnt,
  output logic [15:0]           exc_total
);

  typedef enum logic [1:0] {IDLE, LOOK, HOLD} state_t;

  state_t                state_q;
  logic [9:0]            mask_q;
  logic                  res_valid_q;
  logic                  res_found_q;
  logic [3:0]            res_slot_q;
  logic [DATA_WIDTH-2:0] res_code_q;
  logic [3:0]            res_cnt_q;
  logic [15:0]           exc_total_q;
  logic [15:0]           exc_total_d;

  logic [DATA_WIDTH-1:0] rd [10];
  logic                  scan_found;
  logic [3:0]            scan_slot;
  logic [DATA_WIDTH-2:0] scan_code;
  logic [3:0]            scan_cnt;
  logic                  accept;
  logic                  deliver;

  assign rd[0] = read_data0;
  assign rd[1] = read_data1;
  assign rd[2] = read_data2;
  assign rd[3] = read_data3;
  assign rd[4] = read_data4;
  assign rd[5] = read_data5;
  assign rd[6] = read_data6;
  assign rd[7] = read_data7;
  assign rd[8] = read_data8;
  assign rd[9] = read_data9;

  assign req_ready = rst && (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign read_step = accept;
  assign read_addr = req_addr;

  // Masked slots counted until the first flagged one; if none is flagged this is popcount(mask).
  always_comb begin
    scan_found = 1'b0;
    scan_slot  = 4'd0;
    scan_code  = '0;
    scan_cnt   = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (!scan_found && mask_q[i]) begin
        if (rd[i][0]) begin
          scan_found = 1'b1;
          scan_slot  = 4'(i);
          scan_code  = rd[i][DATA_WIDTH-1:1];
        end else begin
          scan_cnt = scan_cnt + 4'd1;
        end
      end
    end
  end

  assign deliver = (state_q == HOLD) && !flush && res_ready;

  always_comb begin
    exc_total_d = exc_total_q;
    if (deliver && res_found_q && (exc_total_q != 16'hFFFF)) begin
      exc_total_d = exc_total_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_slot_q  <= '0;
      res_code_q  <= '0;
      res_cnt_q   <= '0;
      exc_total_q <= '0;
    end else begin
      exc_total_q <= exc_total_d;
      if (flush) begin
        state_q     <= IDLE;
        res_valid_q <= 1'b0;
        res_found_q <= 1'b0;
        res_slot_q  <= '0;
        res_code_q  <= '0;
        res_cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              mask_q  <= req_mask;
              state_q <= LOOK;
            end
          end
          LOOK: begin
            res_valid_q <= 1'b1;
            res_found_q <= scan_found;
            res_slot_q  <= scan_slot;
            res_code_q  <= scan_code;
            res_cnt_q   <= scan_cnt;
            state_q     <= HOLD;
          end
          HOLD: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              res_found_q <= 1'b0;
              res_slot_q  <= '0;
              res_code_q  <= '0;
              res_cnt_q   <= '0;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign res_valid      = res_valid_q;
  assign res_found      = res_found_q;
  assign res_slot       = res_slot_q;
  assign res_code       = res_code_q;
  assign res_retire_cnt = res_cnt_q;
  assign exc_total      = exc_total_q;

endmodule
